// File: rtl/scan_chain_ctrl.sv
// Scan-test sequencer: shifts a parallel pattern into one scan chain, runs a
// functional capture window, then shifts the response back out as a parallel word.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN      = 16,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 chain_clk_en,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload_data
);

    // Sized for the chain; widened only when a short chain has a long capture window.
    localparam int LEN_W = $clog2(CHAIN_LEN + 1);
    localparam int CAP_W = $clog2(CAPTURE_CYCLES + 1);
    localparam int CNT_W = (LEN_W > CAP_W) ? LEN_W : CAP_W;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [CHAIN_LEN-1:0] load_sr, load_sr_nxt;
    logic [CHAIN_LEN-1:0] unload_sr, unload_sr_nxt;
    logic [CHAIN_LEN-1:0] unload_data_nxt;
    logic                 scan_en_nxt, scan_in_nxt, chain_clk_en_nxt, busy_nxt, done_nxt;
    logic [1:0]           rst_sync;
    logic                 run_ok;

    // Reset asserts asynchronously; release is held off two edges before start is honoured.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_ok = rst_sync[1];

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        load_sr_nxt     = load_sr;
        unload_sr_nxt   = unload_sr;
        unload_data_nxt = unload_data;

        case (state)
            IDLE: begin
                if (run_ok && start && !abort) begin
                    load_sr_nxt = load_data;
                    cnt_nxt     = '0;
                    state_nxt   = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    load_sr_nxt = {1'b0, load_sr[CHAIN_LEN-1:1]};
                    if (cnt == SHIFT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = CAPTURE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == CAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SHIFT_OUT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHIFT_OUT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    // scan_out is the pre-edge Q of cell 0, so cell 0 lands in bit 0 last.
                    unload_sr_nxt = {scan_out, unload_sr[CHAIN_LEN-1:1]};
                    if (cnt == SHIFT_LAST) begin
                        cnt_nxt         = '0;
                        unload_data_nxt = unload_sr_nxt;
                        state_nxt       = DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered with it.
        scan_en_nxt      = (state_nxt == SHIFT_IN) || (state_nxt == SHIFT_OUT);
        chain_clk_en_nxt = (state_nxt == SHIFT_IN) || (state_nxt == CAPTURE) ||
                           (state_nxt == SHIFT_OUT);
        busy_nxt         = chain_clk_en_nxt;
        done_nxt         = (state_nxt == DONE);
        scan_in_nxt      = (state_nxt == SHIFT_IN) ? load_sr_nxt[0] : 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state        <= IDLE;
            cnt          <= '0;
            load_sr      <= '0;
            unload_sr    <= '0;
            unload_data  <= '0;
            scan_en      <= 1'b0;
            scan_in      <= 1'b0;
            chain_clk_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            load_sr      <= load_sr_nxt;
            unload_sr    <= unload_sr_nxt;
            unload_data  <= unload_data_nxt;
            scan_en      <= scan_en_nxt;
            scan_in      <= scan_in_nxt;
            chain_clk_en <= chain_clk_en_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: three sequencers (4/1 inverting chain, 16/1 and 4/3
// identity chains) with behavioural chain models and per-instance scoreboards.
module tb_scan_chain_ctrl;

    logic CLK = 1'b0;
    logic RSTB = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // Instance a: CHAIN_LEN=4, CAPTURE_CYCLES=1, chain captures inverse of each cell
    logic       st_a = 0, ab_a = 0, so_a, se_a, si_a, cce_a, busy_a, done_a;
    logic [3:0] ld_a = '0, ud_a, ch_a = '0;
    // Instance b: defaults, identity capture
    logic        st_b = 0, ab_b = 0, so_b, se_b, si_b, cce_b, busy_b, done_b;
    logic [15:0] ld_b = '0, ud_b, ch_b = '0;
    // Instance c: CHAIN_LEN=4, CAPTURE_CYCLES=3, identity capture
    logic       st_c = 0, ab_c = 0, so_c, se_c, si_c, cce_c, busy_c, done_c;
    logic [3:0] ld_c = '0, ud_c, ch_c = '0;

    scan_chain_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYCLES(1)) u_a (
        .CLK(CLK), .RSTB(RSTB), .start(st_a), .abort(ab_a), .load_data(ld_a),
        .scan_out(so_a), .scan_en(se_a), .scan_in(si_a), .chain_clk_en(cce_a),
        .busy(busy_a), .done(done_a), .unload_data(ud_a));

    scan_chain_ctrl #(.CHAIN_LEN(16), .CAPTURE_CYCLES(1)) u_b (
        .CLK(CLK), .RSTB(RSTB), .start(st_b), .abort(ab_b), .load_data(ld_b),
        .scan_out(so_b), .scan_en(se_b), .scan_in(si_b), .chain_clk_en(cce_b),
        .busy(busy_b), .done(done_b), .unload_data(ud_b));

    scan_chain_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYCLES(3)) u_c (
        .CLK(CLK), .RSTB(RSTB), .start(st_c), .abort(ab_c), .load_data(ld_c),
        .scan_out(so_c), .scan_en(se_c), .scan_in(si_c), .chain_clk_en(cce_c),
        .busy(busy_c), .done(done_c), .unload_data(ud_c));

    // Chain models: SI enters the top cell, cell 0 drives scan_out.
    assign so_a = ch_a[0];
    assign so_b = ch_b[0];
    assign so_c = ch_c[0];

    always @(posedge CLK) begin
        if (cce_a) ch_a <= se_a ? {si_a, ch_a[3:1]} : ~ch_a;
        if (cce_b && se_b) ch_b <= {si_b, ch_b[15:1]};
        if (cce_c && se_c) ch_c <= {si_c, ch_c[3:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitors: each done pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (done_a) begin
            check("a_sb_pending", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                exp_t e;
                e = q_a.pop_front();
                check("a_unload", 32'(ud_a), 32'(e.data));
                check("a_done_edge", cyc, e.cyc);
            end
        end
        if (done_b) begin
            check("b_sb_pending", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                exp_t e;
                e = q_b.pop_front();
                check("b_unload", 32'(ud_b), 32'(e.data));
                check("b_done_edge", cyc, e.cyc);
            end
        end
        if (done_c) begin
            check("c_sb_pending", 32'(q_c.size() != 0), 32'd1);
            if (q_c.size() != 0) begin
                exp_t e;
                e = q_c.pop_front();
                check("c_unload", 32'(ud_c), 32'(e.data));
                check("c_done_edge", cyc, e.cyc);
            end
        end
    end

    task automatic wait_done(input int which, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge CLK);
            seen = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end
        check("wait_done_bound", 32'(seen), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int         s;
        int         cnt;
        int         rises;
        logic       prev;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_a", 32'({se_a, si_a, cce_a, busy_a, done_a, ud_a}), 32'd0);
        check("rst_b", 32'({se_b, si_b, cce_b, busy_b, done_b, ud_b}), 32'd0);
        check("rst_c", 32'({se_c, si_c, cce_c, busy_c, done_c, ud_c}), 32'd0);
        RSTB = 1'b1;
        repeat (3) @(negedge CLK);

        // 4-cell inverting loopback, pattern 1010
        pat  = 4'b1010;
        ld_a = pat;
        st_a = 1'b1;
        q_a.push_back('{16'h0005, cyc + 1 + 9});
        @(negedge CLK);
        st_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("a_shift_in_%0d", k), 32'({se_a, si_a, busy_a}), 32'({1'b1, pat[k], 1'b1}));
            @(negedge CLK);
        end
        check("a_capture_se", 32'({se_a, cce_a}), 32'b01);
        wait_done(0, 20);

        // 16-cell identity chain, busy window length
        @(negedge CLK);
        ld_b = 16'hA5C3;
        st_b = 1'b1;
        q_b.push_back('{16'hA5C3, cyc + 1 + 33});
        @(negedge CLK);
        st_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60 && !done_b; i++) begin
            cnt += int'(busy_b);
            @(negedge CLK);
        end
        check("b_done_seen", 32'(done_b), 32'd1);
        check("b_busy_cycles", cnt, 33);
        check("b_busy_at_done", 32'(busy_b), 32'd0);

        // 3-cycle capture window
        @(negedge CLK);
        ld_c = 4'b0110;
        st_c = 1'b1;
        q_c.push_back('{16'h0006, cyc + 1 + 11});
        @(negedge CLK);
        st_c = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30 && !done_c; i++) begin
            if (busy_c && !se_c) cnt++;
            @(negedge CLK);
        end
        check("c_done_seen", 32'(done_c), 32'd1);
        check("c_capture_cycles", cnt, 3);

        // Abort two cycles into capture
        @(negedge CLK);
        ld_c = 4'b1001;
        st_c = 1'b1;
        @(negedge CLK);
        st_c = 1'b0;
        repeat (5) @(negedge CLK);
        check("c_in_capture", 32'({se_c, cce_c, busy_c}), 32'b011);
        ab_c = 1'b1;
        @(negedge CLK);
        ab_c = 1'b0;
        check("c_abort_idle", 32'({se_c, cce_c, busy_c, done_c}), 32'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            cnt += int'(done_c);
        end
        check("c_abort_no_done", cnt, 0);
        check("c_abort_unload_kept", 32'(ud_c), 32'h6);

        // Reset mid shift-out, then release synchronizer timing
        ld_a = 4'b0011;
        st_a = 1'b1;
        @(negedge CLK);
        st_a = 1'b0;
        repeat (6) @(negedge CLK);
        check("a_in_shift_out", 32'({se_a, cce_a, busy_a}), 32'b111);
        #2 RSTB = 1'b0;
        #1;
        check("a_async_rst", 32'({se_a, si_a, cce_a, busy_a, done_a, ud_a}), 32'd0);
        check("b_async_rst_unload", 32'(ud_b), 32'd0);
        @(negedge CLK);
        RSTB = 1'b1;
        st_a = 1'b1;
        @(negedge CLK);
        check("a_start_edge1_ignored", 32'(busy_a), 32'd0);
        @(negedge CLK);
        check("a_start_edge2_ignored", 32'(busy_a), 32'd0);
        q_a.push_back('{16'h000C, cyc + 1 + 9});
        @(negedge CLK);
        st_a = 1'b0;
        check("a_start_edge3_accepted", 32'(busy_a), 32'd1);
        wait_done(0, 20);

        // start held high across two complete runs
        @(negedge CLK);
        ld_a = 4'b1100;
        st_a = 1'b1;
        s = cyc + 1;
        q_a.push_back('{16'h0003, s + 9});
        q_a.push_back('{16'h0003, s + 20});
        cnt = 0;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (done_a) cnt++;
            if (done_a && !prev) rises++;
            prev = done_a;
            if (cyc == s + 20) st_a = 1'b0;
        end
        check("a_held_done_cycles", cnt, 2);
        check("a_held_done_pulses", rises, 2);
        check("a_held_idle_after", 32'(busy_a), 32'd0);

        check("a_sb_drained", q_a.size(), 0);
        check("b_sb_drained", q_b.size(), 0);
        check("c_sb_drained", q_c.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
